cs_multi_gen: RTL
=================

# cs_multi_gen

Parametrised chip-select sequencer for the equalizer's converter interfaces. It generates one active-low CS per converter channel and serves the channels round-robin, one per sample slot. The slot period and the CS-low width can be reconfigured at run time, and a new configuration takes effect only at a slot boundary. It also emits slot and frame strobes that the ADC/DAC shift logic and the filter pipeline use to align samples. It replaces fixed single-channel CS generation; with the defaults, each slot is 2268 clk cycles (100 MHz / 44.1 kHz) with CS low for 138 cycles.

## Interface
Parameters:
- CNT_W, 12, width of the slot-period counter and of period_i.
- LOW_W, 8, width of the CS-low counter and of low_i.
- NUM_CH, 2, number of CS outputs (≥1).
- CH_W, $clog2(NUM_CH) (minimum 1), width of ch_idx.
- DEF_PERIOD, 2268, slot period in clk cycles after reset.
- DEF_LOW, 138, CS-low width in clk cycles after reset.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable, level-sensitive.
- cfg_load  in  1  one-cycle strobe that captures period_i and low_i.
- period_i  in  CNT_W  requested slot period in cycles.
- low_i  in  LOW_W  requested CS-low width in cycles.
- cs_n  out  NUM_CH  active-low chip selects; at most one bit is low at a time.
- ch_idx  out  CH_W  channel of the current or most recent slot.
- slot_start  out  1  one-cycle pulse on the first CS-low cycle of every slot.
- frame_start  out  1  one-cycle pulse coincident with slot_start when ch_idx = 0.
- sample_done  out  1  one-cycle pulse on the first cycle after a CS-low phase ends.
- cfg_err  out  1  sticky flag: a rejected configuration was loaded; cleared by the next accepted cfg_load.

## Operation
- Three states: IDLE, HIGH, LOW. All outputs are registered.
- Effective high time is H = period − low. low is zero-extended to CNT_W before any arithmetic.
- Configuration validity:
  - cfg_load is accepted only if 1 ≤ low_i and zero-extended low_i < period_i.
  - An accepted load is stored in pending registers.
  - A rejected load sets cfg_err and leaves both the pending and active configuration unchanged.
- Pending configuration becomes active:
  - on the IDLE→HIGH transition, or
  - on the LOW→HIGH transition (the slot boundary).
  - It never takes effect mid-slot. If several loads arrive within one slot, the last accepted one wins.
- IDLE:
  - cs_n is all ones and ch_idx = 0.
  - When en = 1, go to HIGH with the counter at 0.
- HIGH:
  - cs_n is all ones.
  - After H cycles, go to LOW with cs_n[ch_idx] = 0 and slot_start = 1 (plus frame_start if ch_idx = 0).
  - If en = 0 during HIGH, go to IDLE on the next edge.
- LOW:
  - cs_n[ch_idx] = 0 for exactly low cycles.
  - Then deassert CS, pulse sample_done, and advance ch_idx by one, wrapping from NUM_CH−1 to 0.
  - If en is 1, go to HIGH; otherwise go to IDLE.
  - en falling during LOW never truncates the CS pulse.
- Reset (asynchronous, including mid-slot):
  - State = IDLE; cs_n all ones; ch_idx = 0; slot_start = frame_start = sample_done = cfg_err = 0.
  - Counters cleared; active and pending configuration = DEF_PERIOD / DEF_LOW.
- With NUM_CH = 1, every slot_start is also a frame_start.

## Timing
- en is sampled at the clk rising edge. The first edge with en = 1 in IDLE starts HIGH. The first cs_n low occurs H cycles later.
- Each slot is exactly period cycles long: H cycles with cs_n all high, then low cycles with cs_n[ch_idx] low.
- Slots run back to back with no gap cycles. A frame lasts NUM_CH × period cycles.
- Timing of the per-slot pulses:
  - slot_start and cs_n falling are asserted in the same cycle.
  - sample_done and cs_n rising are asserted in the same cycle.
  - ch_idx updates in the same cycle as sample_done.
- cfg_err sets in the cycle after the offending cfg_load.
- A configuration loaded in slot k governs slot k+1 at the earliest.

## Test plan
- Defaults, NUM_CH=2, en held high after reset:
  - cs_n[0] is low for 138 cycles starting at cycle 2130, and cs_n[1] is low for 138 cycles starting at cycle 4398.
  - frame_start occurs every 4536 cycles.
  - cs_n is never 2'b00.
- cfg_load period=100, low=10 arriving mid-HIGH:
  - the current slot keeps 2130/138;
  - the next slot is 90 cycles high then 10 low, with slot_start spacing 100.
- cfg_load with low=0, and cfg_load with low=100 while period=100:
  - cfg_err = 1 and timing is unchanged;
  - a subsequent valid load clears cfg_err.
- en dropped on the 5th CS-low cycle: CS stays low for the full 138 cycles, then sample_done, then IDLE with all cs_n = 1.
- en dropped mid-HIGH: IDLE next cycle with no CS pulse. en re-raised: restarts at ch_idx = 0 with a full H.
- rst asserted mid-LOW: cs_n goes to all ones immediately (asynchronously) with no further pulses; after release, default timing resumes.

Source files
------------

// File: rtl/cs_multi_gen_if.sv
// Control and strobe bundle between the converter sequencer and its client logic.
// The master drives run/config requests; the slave (sequencer) returns chip selects and strobes.
interface cs_multi_gen_if #(
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned LOW_W  = 8,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              en;
  logic              cfg_load;
  logic [CNT_W-1:0]  period_i;
  logic [LOW_W-1:0]  low_i;
  logic [NUM_CH-1:0] cs_n;
  logic [CH_W-1:0]   ch_idx;
  logic              slot_start;
  logic              frame_start;
  logic              sample_done;
  logic              cfg_err;

  modport master (
    output en, cfg_load, period_i, low_i,
    input  cs_n, ch_idx, slot_start, frame_start, sample_done, cfg_err
  );

  modport slave (
    input  en, cfg_load, period_i, low_i,
    output cs_n, ch_idx, slot_start, frame_start, sample_done, cfg_err
  );
endinterface

// File: rtl/cs_multi_gen.sv
// Round-robin active-low chip-select sequencer with run-time slot/CS-low configuration
// applied only at slot boundaries, plus slot/frame/sample strobes for sample alignment.
module cs_multi_gen #(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned LOW_W      = 8,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned DEF_PERIOD = 2268,
  parameter int unsigned DEF_LOW    = 138
) (
  input  logic            clk,
  input  logic            rst,
  cs_multi_gen_if.slave   cs_if
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [LOW_W-1:0]   low_q, low_d;
  logic [CNT_W-1:0]   pend_period_q, pend_period_d;
  logic [LOW_W-1:0]   pend_low_q, pend_low_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [NUM_CH-1:0]  cs_n_q, cs_n_d;
  logic               slot_q, slot_d;
  logic               frame_q, frame_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               cfg_ok_c;
  logic [CNT_W-1:0]   high_last_c;
  logic [CNT_W-1:0]   low_last_c;
  logic [CH_W-1:0]    ch_next_c;

  // low is zero-extended before comparing/subtracting; a valid config guarantees H >= 1
  assign cfg_ok_c    = (cs_if.low_i != '0) && (CNT_W'(cs_if.low_i) < cs_if.period_i);
  assign high_last_c = period_q - CNT_W'(low_q) - CNT_W'(1);
  assign low_last_c  = CNT_W'(low_q) - CNT_W'(1);
  assign ch_next_c   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      period_q      <= CNT_W'(DEF_PERIOD);
      low_q         <= LOW_W'(DEF_LOW);
      pend_period_q <= CNT_W'(DEF_PERIOD);
      pend_low_q    <= LOW_W'(DEF_LOW);
      ch_q          <= '0;
      cs_n_q        <= '1;
      slot_q        <= 1'b0;
      frame_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      low_q         <= low_d;
      pend_period_q <= pend_period_d;
      pend_low_q    <= pend_low_d;
      ch_q          <= ch_d;
      cs_n_q        <= cs_n_d;
      slot_q        <= slot_d;
      frame_q       <= frame_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    period_d      = period_q;
    low_d         = low_q;
    pend_period_d = pend_period_q;
    pend_low_d    = pend_low_q;
    ch_d          = ch_q;
    cs_n_d        = cs_n_q;
    slot_d        = 1'b0;
    frame_d       = 1'b0;
    done_d        = 1'b0;
    err_d         = err_q;

    // Last accepted load in a slot wins; rejected loads only flag the error
    if (cs_if.cfg_load) begin
      if (cfg_ok_c) begin
        pend_period_d = cs_if.period_i;
        pend_low_d    = cs_if.low_i;
        err_d         = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        cs_n_d = '1;
        ch_d   = '0;
        cnt_d  = '0;
        if (cs_if.en) begin
          state_d  = HIGH;
          period_d = pend_period_q;
          low_d    = pend_low_q;
        end
      end
      HIGH: begin
        if (!cs_if.en) begin
          state_d = IDLE;
          cnt_d   = '0;
          ch_d    = '0;
          cs_n_d  = '1;
        end else if (cnt_q == high_last_c) begin
          state_d = LOW;
          cnt_d   = '0;
          cs_n_d  = ~(NUM_CH'(1) << ch_q);
          slot_d  = 1'b1;
          frame_d = (ch_q == '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOW: begin
        // en is ignored until the CS pulse has run its full width
        if (cnt_q == low_last_c) begin
          cs_n_d = '1;
          done_d = 1'b1;
          cnt_d  = '0;
          if (cs_if.en) begin
            state_d  = HIGH;
            ch_d     = ch_next_c;
            period_d = pend_period_q;
            low_d    = pend_low_q;
          end else begin
            state_d = IDLE;
            ch_d    = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cs_n_d  = '1;
        ch_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign cs_if.cs_n        = cs_n_q;
  assign cs_if.ch_idx      = ch_q;
  assign cs_if.slot_start  = slot_q;
  assign cs_if.frame_start = frame_q;
  assign cs_if.sample_done = done_q;
  assign cs_if.cfg_err     = err_q;

endmodule
